// File: rtl/branch_predictor_if.sv
// Fetch/execute-side signal bundle between the core pipeline and the branch predictor.
// Latency: none (wiring only); prediction is combinational, execute state is one cycle behind fetch.
// Backpressure: stall holds the predictor's execute register, table and statistics.
interface branch_predictor_if;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_valid;
    logic        stall;
    logic        ex_taken;
    logic [1:0]  predict_o;
    logic [1:0]  ex_pred_o;
    logic        mispredict_o;
    logic [31:0] branch_cnt_o;
    logic [31:0] miss_cnt_o;

    // Core pipeline side: drives fetch/execute status, consumes predictions.
    modport master (
        output if_pc, if_inst, if_valid, stall, ex_taken,
        input  predict_o, ex_pred_o, mispredict_o, branch_cnt_o, miss_cnt_o
    );

    // Predictor side.
    modport slave (
        input  if_pc, if_inst, if_valid, stall, ex_taken,
        output predict_o, ex_pred_o, mispredict_o, branch_cnt_o, miss_cnt_o
    );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped 2-bit saturating-counter branch predictor with mispredict detect and MMIO stats.
// Latency: predict_o combinational in fetch; ex_pred_o one cycle later; table write visible next cycle.
// Backpressure: stall=1 freezes execute register, table and counters; mispredict_o stays live.
module branch_predictor #(
    parameter int         INDEX_BITS   = 6,
    parameter logic [1:0] COUNTER_INIT = 2'b01
) (
    input  logic               clk,
    input  logic               rst,
    branch_predictor_if.slave  bp
);
    localparam int ENTRIES = 1 << INDEX_BITS;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [1:0] PRED_TAKEN = 2'b10;
    localparam logic [1:0] PRED_NT    = 2'b01;
    localparam logic [1:0] PRED_NONE  = 2'b00;

    logic [1:0]            ctr_tbl [ENTRIES];
    logic [INDEX_BITS-1:0] if_idx;
    logic [INDEX_BITS-1:0] ex_idx;
    logic [1:0]            ex_pred;
    logic [1:0]            if_ctr;
    logic [1:0]            ex_ctr;
    logic [1:0]            ctr_nxt;
    logic [1:0]            predict;
    logic                  is_branch;
    logic                  mispredict;
    logic                  train;
    logic [31:0]           branch_cnt;
    logic [31:0]           miss_cnt;

    // Only B-type conditional branches are predicted; jumps resolve elsewhere.
    assign is_branch = bp.if_valid && (bp.if_inst[6:0] == OPC_BRANCH);
    assign if_idx    = bp.if_pc[INDEX_BITS+1:2];
    assign if_ctr    = ctr_tbl[if_idx];
    assign ex_ctr    = ctr_tbl[ex_idx];

    assign predict    = is_branch ? (if_ctr[1] ? PRED_TAKEN : PRED_NT) : PRED_NONE;
    assign mispredict = ((ex_pred == PRED_TAKEN) && !bp.ex_taken) ||
                        ((ex_pred == PRED_NT)    &&  bp.ex_taken);
    assign train      = !bp.stall && (ex_pred != PRED_NONE);

    // Saturating increment/decrement of the counter belonging to the branch in execute.
    always_comb begin
        ctr_nxt = ex_ctr;
        if (bp.ex_taken) begin
            if (ex_ctr != 2'b11) ctr_nxt = ex_ctr + 2'b01;
        end else begin
            if (ex_ctr != 2'b00) ctr_nxt = ex_ctr - 2'b01;
        end
    end

    // Counter table: trained once per resolved branch; lookup in the same cycle sees the old value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) ctr_tbl[i] <= COUNTER_INIT;
        end else if (train) begin
            ctr_tbl[ex_idx] <= ctr_nxt;
        end
    end

    // Fetch-to-execute register; a mispredict squashes the wrong-path fetch slot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_pred <= PRED_NONE;
            ex_idx  <= '0;
        end else if (!bp.stall) begin
            if (mispredict) begin
                ex_pred <= PRED_NONE;
            end else begin
                ex_pred <= predict;
                ex_idx  <= if_idx;
            end
        end
    end

    // Branch and miss statistics, free-running modulo 2^32.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            branch_cnt <= '0;
            miss_cnt   <= '0;
        end else if (train) begin
            branch_cnt <= branch_cnt + 32'd1;
            if (mispredict) miss_cnt <= miss_cnt + 32'd1;
        end
    end

    assign bp.predict_o    = predict;
    assign bp.ex_pred_o    = ex_pred;
    assign bp.mispredict_o = mispredict;
    assign bp.branch_cnt_o = branch_cnt;
    assign bp.miss_cnt_o   = miss_cnt;
endmodule
